// File: rtl/div_pkg.sv
// div_pkg -- shared constants for the arithmetic-unit control FSMs.
// Holds the 2-bit state encodings (OCIOSO/CARGA/SUBTRAI/PRONTO) and the
// default operand width. The multiplier control imports the same encodings.
// Optional feature macro used by the divider: DIV_CICLOS_EN.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CARGA   = 2'b01,
    SUBTRAI = 2'b10,
    PRONTO  = 2'b11
  } div_estado_t;

endpackage

// File: rtl/divisor_subtracao_if.sv
// divisor_subtracao_if -- START/PRONTO handshake and operand/result bus of
// the repeated-subtraction divider.
//   START, DIVIDENDO, DIVISOR      : sequencer -> divider
//   QUOCIENTE, RESTO               : result registers
//   OCUPADO, PRONTO, ERRO_DIV0     : status
//   CICLOS                         : SUBTRAI cycle count (only with DIV_CICLOS_EN)
// Modports: master (sequencer side), slave (divider side).
interface divisor_subtracao_if #(
  parameter int WIDTH = 8
) ();
  logic             START;
  logic [WIDTH-1:0] DIVIDENDO;
  logic [WIDTH-1:0] DIVISOR;
  logic [WIDTH-1:0] QUOCIENTE;
  logic [WIDTH-1:0] RESTO;
  logic             OCUPADO;
  logic             PRONTO;
  logic             ERRO_DIV0;
`ifdef DIV_CICLOS_EN
  logic [WIDTH:0]   CICLOS;

  modport master (
    output START, DIVIDENDO, DIVISOR,
    input  QUOCIENTE, RESTO, OCUPADO, PRONTO, ERRO_DIV0, CICLOS
  );
  modport slave (
    input  START, DIVIDENDO, DIVISOR,
    output QUOCIENTE, RESTO, OCUPADO, PRONTO, ERRO_DIV0, CICLOS
  );
`else
  modport master (
    output START, DIVIDENDO, DIVISOR,
    input  QUOCIENTE, RESTO, OCUPADO, PRONTO, ERRO_DIV0
  );
  modport slave (
    input  START, DIVIDENDO, DIVISOR,
    output QUOCIENTE, RESTO, OCUPADO, PRONTO, ERRO_DIV0
  );
`endif
endinterface

// File: rtl/subtrator_comparador.sv
// subtrator_comparador -- combinational unsigned compare and subtract.
//   a, b : WIDTH-bit unsigned operands
//   ge   : a >= b
//   dif  : a - b (only meaningful when ge=1)
module subtrator_comparador #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge,
  output logic [WIDTH-1:0] dif
);
  assign ge  = (a >= b);
  assign dif = a - b;
endmodule

// File: rtl/divisor_subtracao.sv
// divisor_subtracao -- unsigned divider by repeated subtraction.
// Ports:
//   CLK      : rising-edge clock
//   RESET_N  : asynchronous active-low reset (aborts any operation)
//   bus      : divisor_subtracao_if.slave (START/operands in, results/status out)
// An operation is accepted when START=1 in OCIOSO or PRONTO. RESTO starts at
// the dividend and the divisor is subtracted once per SUBTRAI cycle while it
// fits; QUOCIENTE counts the subtractions. Divisor 0 finishes straight from
// CARGA with ERRO_DIV0=1 and QUOCIENTE all ones.
// Optional macro DIV_CICLOS_EN adds bus.CICLOS, the number of SUBTRAI cycles
// of the current operation (Q+1, or 0 on divide-by-zero).
module divisor_subtracao
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic                 CLK,
  input logic                 RESET_N,
  divisor_subtracao_if.slave  bus
);

  div_estado_t      r_estado;
  div_estado_t      w_prox;
  logic [WIDTH-1:0] r_quoc;
  logic [WIDTH-1:0] r_resto;
  logic [WIDTH-1:0] r_div;
  logic             r_erro;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  logic             w_captura;

  subtrator_comparador #(.WIDTH(WIDTH)) u_sub (
    .a   (r_resto),
    .b   (r_div),
    .ge  (w_ge),
    .dif (w_dif)
  );

  // START only matters in the two resting states.
  assign w_captura = bus.START && ((r_estado == OCIOSO) || (r_estado == PRONTO));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_estado <= OCIOSO;
    else          r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (bus.START) w_prox = CARGA;
      CARGA:   w_prox = (r_div == '0) ? PRONTO : SUBTRAI;
      SUBTRAI: if (!w_ge) w_prox = PRONTO;
      PRONTO:  if (bus.START) w_prox = CARGA;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_quoc  <= '0;
      r_resto <= '0;
      r_div   <= '0;
      r_erro  <= 1'b0;
    end else if (w_captura) begin
      r_resto <= bus.DIVIDENDO;
      r_div   <= bus.DIVISOR;
      r_quoc  <= '0;
      r_erro  <= 1'b0;
    end else if (r_estado == CARGA) begin
      if (r_div == '0) begin
        r_erro <= 1'b1;
        r_quoc <= '1;
      end
    end else if ((r_estado == SUBTRAI) && w_ge) begin
      // Leaves SUBTRAI with registers untouched on the first failing compare.
      r_resto <= w_dif;
      r_quoc  <= r_quoc + WIDTH'(1);
    end
  end

`ifdef DIV_CICLOS_EN
  logic [WIDTH:0] r_ciclos;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                  r_ciclos <= '0;
    else if (w_captura)            r_ciclos <= '0;
    else if (r_estado == SUBTRAI)  r_ciclos <= r_ciclos + (WIDTH+1)'(1);
  end

  assign bus.CICLOS = r_ciclos;
`endif

  assign bus.QUOCIENTE = r_quoc;
  assign bus.RESTO     = r_resto;
  assign bus.ERRO_DIV0 = r_erro;
  assign bus.OCUPADO   = (r_estado == CARGA) || (r_estado == SUBTRAI);
  assign bus.PRONTO    = (r_estado == PRONTO);

endmodule
